// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states, opcodes and select encodings for the cpu controller
package cpu_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ALU,
        S_LDC,
        S_ABS,
        S_JMPZ,
        S_JMPZ_T,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'h0,
        OP_STORE = 4'h1,
        OP_ADD   = 4'h2,
        OP_LDC   = 4'h3,
        OP_SUB   = 4'h4,
        OP_JMPZ  = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_ABS   = 4'h8,
        OP_HALT  = 4'hF
    } opcode_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] WSEL_ALU   = 2'b00;
    localparam logic [1:0] WSEL_DM    = 2'b01;
    localparam logic [1:0] WSEL_CONST = 2'b10;
    localparam logic [1:0] WSEL_ABS   = 2'b11;

    function automatic logic [1:0] alu_op_of(input logic [3:0] op);
        if (op == OP_SUB)      return ALU_SUB;
        else if (op == OP_AND) return ALU_AND;
        else if (op == OP_OR)  return ALU_OR;
        else                   return ALU_ADD;
    endfunction

    // Opcodes 9..E carry no operation and retire straight from decode
    function automatic logic is_nop(input logic [3:0] op);
        return (op >= 4'h9) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/cpu_pc.sv
// rtl/cpu_pc.sv - program counter with reset, increment and relative branch load
module cpu_pc #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_reset,
    input  logic            inc,
    input  logic            branch,
    input  logic [7:0]      offset,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] offset_ext;

    assign offset_ext = {{(PC_W-8){offset[7]}}, offset};

    // pc already points past the branch, hence the -1 in the target
    always_ff @(posedge clk) begin
        if (rst || load_reset) begin
            pc <= RESET_PC;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end else if (branch) begin
            pc <= pc + offset_ext - PC_W'(1);
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle control unit; CPU_CONTROLLER_INSTR_CNT_EN adds instr_count
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] I_addr,
    output logic            I_rd,
    input  logic [15:0]     I_data,
    output logic [7:0]      D_addr,
    output logic            D_rd,
    output logic            D_wr,
    output logic            RF_s0,
    output logic            RF_s1,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_wr,
    output logic [3:0]      RF_Rp_addr,
    output logic            RF_Rp_rd,
    output logic [3:0]      RF_Rq_addr,
    output logic            RF_Rq_rd,
    output logic [7:0]      RF_W_cons,
    output logic            alu_s0,
    output logic            alu_s1,
    input  logic            RF_Rp_zero,
    output logic            halted
`ifdef CPU_CONTROLLER_INSTR_CNT_EN
    ,
    output logic [31:0]     instr_count
`endif
);

    state_t      state;
    logic [15:0] ir;
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [7:0]  d;
    logic [1:0]  wsel;
    logic [1:0]  alu_op;

    assign op = ir[15:12];
    assign ra = ir[11:8];
    assign rb = ir[7:4];
    assign rc = ir[3:0];
    assign d  = ir[7:0];

    cpu_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_reset (state == S_INIT),
        .inc        (state == S_FETCH),
        .branch     (state == S_JMPZ_T),
        .offset     (d),
        .pc         (I_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            ir    <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    ir    <= '0;
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    ir    <= I_data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_LOAD:                      state <= S_LOAD;
                        OP_STORE:                     state <= S_STORE;
                        OP_ADD, OP_SUB, OP_AND, OP_OR: state <= S_ALU;
                        OP_LDC:                       state <= S_LDC;
                        OP_ABS:                       state <= S_ABS;
                        OP_JMPZ:                      state <= S_JMPZ;
                        OP_HALT:                      state <= S_HALT;
                        default:                      state <= S_FETCH;
                    endcase
                end
                S_JMPZ:  state <= RF_Rp_zero ? S_JMPZ_T : S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Outputs are gated by rst so nothing is written during the reset cycle
    always_comb begin
        I_rd       = 1'b0;
        D_addr     = '0;
        D_rd       = 1'b0;
        D_wr       = 1'b0;
        wsel       = WSEL_ALU;
        RF_W_addr  = '0;
        RF_W_wr    = 1'b0;
        RF_Rp_addr = '0;
        RF_Rp_rd   = 1'b0;
        RF_Rq_addr = '0;
        RF_Rq_rd   = 1'b0;
        RF_W_cons  = '0;
        alu_op     = ALU_ADD;
        halted     = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: I_rd = 1'b1;
                S_LOAD: begin
                    D_addr    = d;
                    D_rd      = 1'b1;
                    wsel      = WSEL_DM;
                    RF_W_addr = ra;
                    RF_W_wr   = 1'b1;
                end
                S_STORE: begin
                    D_addr     = d;
                    D_wr       = 1'b1;
                    RF_Rp_addr = ra;
                    RF_Rp_rd   = 1'b1;
                end
                S_ALU: begin
                    RF_Rp_addr = rb;
                    RF_Rp_rd   = 1'b1;
                    RF_Rq_addr = rc;
                    RF_Rq_rd   = 1'b1;
                    alu_op     = alu_op_of(op);
                    wsel       = WSEL_ALU;
                    RF_W_addr  = ra;
                    RF_W_wr    = 1'b1;
                end
                S_LDC: begin
                    RF_W_cons = d;
                    wsel      = WSEL_CONST;
                    RF_W_addr = ra;
                    RF_W_wr   = 1'b1;
                end
                S_ABS: begin
                    RF_Rp_addr = rb;
                    RF_Rp_rd   = 1'b1;
                    wsel       = WSEL_ABS;
                    RF_W_addr  = ra;
                    RF_W_wr    = 1'b1;
                end
                S_JMPZ: begin
                    RF_Rp_addr = ra;
                    RF_Rp_rd   = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign {RF_s1, RF_s0}   = wsel;
    assign {alu_s1, alu_s0} = alu_op;

`ifdef CPU_CONTROLLER_INSTR_CNT_EN
    logic retire;

    assign retire = (state == S_LOAD) || (state == S_STORE) || (state == S_ALU) ||
                    (state == S_LDC)  || (state == S_ABS)   || (state == S_JMPZ) ||
                    ((state == S_DECODE) && is_nop(op));

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= '0;
        end else if (retire && (instr_count != 32'hFFFF_FFFF)) begin
            instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - self-checking bench for cpu_controller against an instruction-level model
module tb_cpu_controller;

    logic        clk;
    logic        rst;
    logic [15:0] I_addr;
    logic        I_rd;
    logic [15:0] I_data;
    logic [7:0]  D_addr;
    logic        D_rd;
    logic        D_wr;
    logic        RF_s0;
    logic        RF_s1;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Rp_addr;
    logic        RF_Rp_rd;
    logic [3:0]  RF_Rq_addr;
    logic        RF_Rq_rd;
    logic [7:0]  RF_W_cons;
    logic        alu_s0;
    logic        alu_s1;
    logic        RF_Rp_zero;
    logic        halted;
`ifdef CPU_CONTROLLER_INSTR_CNT_EN
    logic [31:0] instr_count;
`endif

    logic [15:0] rom [0:255];
    int          passed;
    int          total;

    assign I_data = rom[I_addr[7:0]];

    cpu_controller #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .I_addr     (I_addr),
        .I_rd       (I_rd),
        .I_data     (I_data),
        .D_addr     (D_addr),
        .D_rd       (D_rd),
        .D_wr       (D_wr),
        .RF_s0      (RF_s0),
        .RF_s1      (RF_s1),
        .RF_W_addr  (RF_W_addr),
        .RF_W_wr    (RF_W_wr),
        .RF_Rp_addr (RF_Rp_addr),
        .RF_Rp_rd   (RF_Rp_rd),
        .RF_Rq_addr (RF_Rq_addr),
        .RF_Rq_rd   (RF_Rq_rd),
        .RF_W_cons  (RF_W_cons),
        .alu_s0     (alu_s0),
        .alu_s1     (alu_s1),
        .RF_Rp_zero (RF_Rp_zero),
        .halted     (halted)
`ifdef CPU_CONTROLLER_INSTR_CNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [54:0] vec(input logic [15:0] ia, input logic ird, input logic [7:0] da,
                                        input logic drd, input logic dwr, input logic [1:0] ws,
                                        input logic [3:0] wa, input logic wwr, input logic [3:0] pa,
                                        input logic [3:0] qa, input logic prd, input logic qrd,
                                        input logic [7:0] cons, input logic [1:0] alu, input logic h);
        return {ia, ird, da, drd, dwr, ws, wa, wwr, pa, qa, prd, qrd, cons, alu, h};
    endfunction

    function automatic logic [54:0] obs();
        return vec(I_addr, I_rd, D_addr, D_rd, D_wr, {RF_s1, RF_s0}, RF_W_addr, RF_W_wr,
                   RF_Rp_addr, RF_Rq_addr, RF_Rp_rd, RF_Rq_rd, RF_W_cons, {alu_s1, alu_s0}, halted);
    endfunction

    function automatic logic [54:0] idle(input logic [15:0] pc);
        return vec(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [54:0] fetch(input logic [15:0] pc);
        return vec(pc, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Execute-cycle outputs straight from the instruction table
    function automatic logic [54:0] exp_exec(input logic [15:0] ir, input logic [15:0] pc);
        logic [3:0] op = ir[15:12];
        logic [3:0] ra = ir[11:8];
        logic [3:0] rb = ir[7:4];
        logic [3:0] rc = ir[3:0];
        logic [7:0] d  = ir[7:0];
        case (op)
            4'h0: return vec(pc, 0, d, 1, 0, 2'b01, ra, 1, 0, 0, 0, 0, 0, 0, 0);
            4'h1: return vec(pc, 0, d, 0, 1, 2'b00, 0, 0, ra, 0, 1, 0, 0, 0, 0);
            4'h2: return vec(pc, 0, 0, 0, 0, 2'b00, ra, 1, rb, rc, 1, 1, 0, 2'b00, 0);
            4'h4: return vec(pc, 0, 0, 0, 0, 2'b00, ra, 1, rb, rc, 1, 1, 0, 2'b01, 0);
            4'h6: return vec(pc, 0, 0, 0, 0, 2'b00, ra, 1, rb, rc, 1, 1, 0, 2'b10, 0);
            4'h7: return vec(pc, 0, 0, 0, 0, 2'b00, ra, 1, rb, rc, 1, 1, 0, 2'b11, 0);
            4'h3: return vec(pc, 0, 0, 0, 0, 2'b10, ra, 1, 0, 0, 0, 0, d, 0, 0);
            4'h8: return vec(pc, 0, 0, 0, 0, 2'b11, ra, 1, rb, 0, 1, 0, 0, 0, 0);
            4'h5: return vec(pc, 0, 0, 0, 0, 2'b00, 0, 0, ra, 0, 1, 0, 0, 0, 0);
            default: return idle(pc);
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 256; i++) rom[i] = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        RF_Rp_zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        fill_rom(16'h9000);
        rom[0] = 16'h3105;
        do_reset();
        total++;
        if (obs() !== idle(16'h0000))
            $display("FAIL reset_init: got %h expected %h", obs(), idle(16'h0000));
        else passed++;
    endtask

    task automatic test_ldc();
        cycles(1);
        total++;
        if (obs() !== fetch(16'h0000)) $display("FAIL ldc_fetch: got %h expected %h", obs(), fetch(16'h0000));
        else passed++;
        cycles(1);
        total++;
        if (obs() !== idle(16'h0001)) $display("FAIL ldc_decode: got %h expected %h", obs(), idle(16'h0001));
        else passed++;
        cycles(1);
        total++;
        if (obs() !== vec(16'h0001, 0, 0, 0, 0, 2'b10, 4'd1, 1, 0, 0, 0, 0, 8'h05, 0, 0))
            $display("FAIL ldc_exec: got %h expected W_addr=1 s=10 cons=05", obs());
        else passed++;
        cycles(1);
        total++;
        if (obs() !== fetch(16'h0001)) $display("FAIL ldc_next_fetch: got %h expected %h", obs(), fetch(16'h0001));
        else passed++;
    endtask

    task automatic test_load_store();
        fill_rom(16'h9000);
        rom[0] = 16'h0010;
        rom[1] = 16'h1220;
        do_reset();
        cycles(3);
        total++;
        if (obs() !== vec(16'h0001, 0, 8'h10, 1, 0, 2'b01, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL load_exec: got %h expected D_addr=10 D_rd=1 s=01", obs());
        else passed++;
        cycles(3);
        total++;
        if (obs() !== vec(16'h0002, 0, 8'h20, 0, 1, 2'b00, 0, 0, 4'd2, 0, 1, 0, 0, 0, 0))
            $display("FAIL store_exec: got %h expected D_addr=20 D_wr=1 Rp=2", obs());
        else passed++;
    endtask

    task automatic test_alu_abs();
        fill_rom(16'h9000);
        rom[0] = 16'h4312;
        rom[1] = 16'h8430;
        do_reset();
        cycles(3);
        total++;
        if (obs() !== vec(16'h0001, 0, 0, 0, 0, 2'b00, 4'd3, 1, 4'd1, 4'd2, 1, 1, 0, 2'b01, 0))
            $display("FAIL sub_exec: got %h expected Rp=1 Rq=2 alu=01 W=3", obs());
        else passed++;
        cycles(3);
        total++;
        if (obs() !== vec(16'h0002, 0, 0, 0, 0, 2'b11, 4'd4, 1, 4'd3, 0, 1, 0, 0, 0, 0))
            $display("FAIL abs_exec: got %h expected Rp=3 s=11 W=4", obs());
        else passed++;
    endtask

    task automatic test_nop_jmpz();
        fill_rom(16'h9000);
        rom[4] = 16'h50FE;
        for (int taken = 1; taken >= 0; taken--) begin
            do_reset();
            cycles(3);
            total++;
            if (obs() !== fetch(16'h0001)) $display("FAIL nop_two_cycles: got %h expected %h", obs(), fetch(16'h0001));
            else passed++;
            cycles(6);
            total++;
            if (obs() !== fetch(16'h0004)) $display("FAIL jmpz_fetch: got %h expected %h", obs(), fetch(16'h0004));
            else passed++;
            cycles(2);
            total++;
            if (obs() !== vec(16'h0005, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0))
                $display("FAIL jmpz_exec: got %h expected Rp_rd=1 Rp=0", obs());
            else passed++;
            RF_Rp_zero = taken[0];
            cycles(1);
            RF_Rp_zero = 1'b0;
            if (taken == 1) begin
                total++;
                if (obs() !== idle(16'h0005)) $display("FAIL jmpz_t: got %h expected %h", obs(), idle(16'h0005));
                else passed++;
                cycles(1);
                total++;
                if (obs() !== fetch(16'h0002)) $display("FAIL jmpz_taken_target: got %h expected %h", obs(), fetch(16'h0002));
                else passed++;
            end else begin
                total++;
                if (obs() !== fetch(16'h0005)) $display("FAIL jmpz_not_taken: got %h expected %h", obs(), fetch(16'h0005));
                else passed++;
            end
        end
    endtask

    task automatic test_halt();
        fill_rom(16'h9000);
        rom[0] = 16'hF000;
        do_reset();
        cycles(3);
        for (int i = 0; i < 12; i++) begin
            total++;
            if (obs() !== vec(16'h0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1))
                $display("FAIL halt_hold[%0d]: got %h expected halted only", i, obs());
            else passed++;
            RF_Rp_zero = 1'($urandom);
            cycles(1);
        end
        do_reset();
        total++;
        if (obs() !== idle(16'h0000)) $display("FAIL halt_reset: got %h expected %h", obs(), idle(16'h0000));
        else passed++;
    endtask

    task automatic test_reset_mid_load();
        fill_rom(16'h9000);
        rom[0] = 16'h0010;
        do_reset();
        cycles(3);
        rst = 1'b1;
        #1;
        total++;
        if ({D_rd, D_wr, RF_W_wr} !== 3'b000)
            $display("FAIL reset_cycle_strobes: got %b expected 000", {D_rd, D_wr, RF_W_wr});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (obs() !== idle(16'h0000)) $display("FAIL reset_mid_load: got %h expected %h", obs(), idle(16'h0000));
        else passed++;
    endtask

`ifdef CPU_CONTROLLER_INSTR_CNT_EN
    task automatic test_instr_count();
        fill_rom(16'h9000);
        rom[0] = 16'h3105;
        rom[1] = 16'h9000;
        rom[2] = 16'h2123;
        rom[3] = 16'hF000;
        do_reset();
        total++;
        if (instr_count !== 32'd0) $display("FAIL count_reset: got %0d expected 0", instr_count);
        else passed++;
        cycles(9);
        total++;
        if (instr_count !== 32'd3) $display("FAIL count_three: got %0d expected 3", instr_count);
        else passed++;
        cycles(20);
        total++;
        if (instr_count !== 32'd3) $display("FAIL count_halt_frozen: got %0d expected 3", instr_count);
        else passed++;
    endtask
`endif

    // Instruction-level model: walk the program, predicting each cycle's outputs
    task automatic test_random();
        logic [15:0] pc;
        logic [15:0] ir;
        logic [3:0]  op;
        logic        z;
        for (int prog = 0; prog < 20; prog++) begin
            for (int i = 0; i < 256; i++) begin
                op = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
                rom[i] = {op, 12'($urandom)};
            end
            do_reset();
            pc = 16'h0000;
            total++;
            if (obs() !== idle(pc)) $display("FAIL rand_init: got %h expected %h", obs(), idle(pc));
            else passed++;
            cycles(1);
            for (int k = 0; k < 40; k++) begin
                ir = rom[pc[7:0]];
                op = ir[15:12];
                total++;
                if (obs() !== fetch(pc)) $display("FAIL rand_fetch: got %h expected %h", obs(), fetch(pc));
                else passed++;
                RF_Rp_zero = 1'($urandom);
                cycles(1);
                pc = pc + 16'd1;
                total++;
                if (obs() !== idle(pc)) $display("FAIL rand_decode: got %h expected %h", obs(), idle(pc));
                else passed++;
                cycles(1);
                if (op == 4'hF) begin
                    for (int h = 0; h < 4; h++) begin
                        total++;
                        if (obs() !== vec(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1))
                            $display("FAIL rand_halt: got %h expected halted at %h", obs(), pc);
                        else passed++;
                        cycles(1);
                    end
                    break;
                end
                if (op >= 4'h9) continue;
                total++;
                if (obs() !== exp_exec(ir, pc))
                    $display("FAIL rand_exec ir=%h: got %h expected %h", ir, obs(), exp_exec(ir, pc));
                else passed++;
                z = 1'($urandom);
                RF_Rp_zero = z;
                cycles(1);
                if (op == 4'h5 && z) begin
                    total++;
                    if (obs() !== idle(pc)) $display("FAIL rand_jmpz_t: got %h expected %h", obs(), idle(pc));
                    else passed++;
                    cycles(1);
                    pc = 16'(pc + {{8{ir[7]}}, ir[7:0]} - 16'd1);
                end
            end
        end
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b1;
        RF_Rp_zero = 1'b0;
        fill_rom(16'h9000);
        cycles(2);
        test_reset();
        test_ldc();
        test_load_store();
        test_alu_abs();
        test_nop_jmpz();
        test_halt();
        test_reset_mid_load();
`ifdef CPU_CONTROLLER_INSTR_CNT_EN
        test_instr_count();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
